// File: rtl/fire_sensor_scanner.sv
// Smoke sensor front end: synchronises and debounces 16 room lines, then
// scans the debounced state once per sample period and publishes a coherent
// room bitmap / count / severity snapshot with a one-cycle update strobe.
module fire_sensor_scanner #(
   parameter int unsigned TICK_DIV     = 1000,
   parameter int unsigned DEBOUNCE     = 4,
   parameter int unsigned MAJOR_THRESH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sensor_raw,
   input  logic [15:0] room_mask,
   output logic [15:0] room,
   output logic [7:0]  count,
   output logic [1:0]  signal,
   output logic        update
);

   localparam int unsigned TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUBLISH} state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic [15:0]   r_sync1;
   logic [15:0]   r_sync2;
   logic [TW-1:0] r_tick;
   logic          w_sample;
   logic          r_sample_d;
   logic [15:0]   r_st;
   logic [15:0]   w_st_nx;
   logic [3:0]    r_dc    [16];
   logic [3:0]    w_dc_nx [16];
   logic [15:0]   r_snap;
   logic [3:0]    r_idx;
   logic [4:0]    r_acc;
   logic [1:0]    w_sev;
   logic [15:0]   r_room;
   logic [7:0]    r_count;
   logic [1:0]    r_signal;
   logic          r_update;

   assign w_sample = (r_tick == TW'(TICK_DIV - 1));

   // Two-flop synchroniser for the asynchronous sensor lines
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sensor_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running sample-period counter plus a delayed copy of the sample flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick     <= '0;
         r_sample_d <= 1'b0;
      end else begin
         r_tick     <= w_sample ? '0 : r_tick + TW'(1);
         r_sample_d <= w_sample;
      end
   end

   // Per-room debounce next state; masking overrides it on every cycle
   always_comb begin
      for (int unsigned i = 0; i < 16; i++) begin
         w_st_nx[i] = r_st[i];
         w_dc_nx[i] = r_dc[i];
         if (room_mask[i]) begin
            w_st_nx[i] = 1'b0;
            w_dc_nx[i] = '0;
         end else if (w_sample) begin
            if (r_sync2[i] == r_st[i]) begin
               w_dc_nx[i] = '0;
            end else if (({1'b0, r_dc[i]} + 5'd1) == 5'(DEBOUNCE)) begin
               w_st_nx[i] = r_sync2[i];
               w_dc_nx[i] = '0;
            end else begin
               w_dc_nx[i] = r_dc[i] + 4'd1;
            end
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_st <= '0;
         for (int unsigned i = 0; i < 16; i++) r_dc[i] <= '0;
      end else begin
         r_st <= w_st_nx;
         for (int unsigned i = 0; i < 16; i++) r_dc[i] <= w_dc_nx[i];
      end
   end

   // Scan FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   // Scan FSM next state
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:    if (r_sample_d) w_state_nx = S_SCAN;
         S_SCAN:    if (r_idx == 4'd15) w_state_nx = S_PUBLISH;
         S_PUBLISH: w_state_nx = S_IDLE;
         default:   w_state_nx = S_IDLE;
      endcase
   end

   // Severity classification of the finished accumulation
   always_comb begin
      w_sev = 2'b11;
      if (r_acc == 5'd0)                       w_sev = 2'b00;
      else if (r_acc == 5'd1)                  w_sev = 2'b01;
      else if (r_acc < 5'(MAJOR_THRESH))       w_sev = 2'b10;
   end

   // Snapshot, serial accumulate and publish; outputs only move together
   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap   <= '0;
         r_idx    <= '0;
         r_acc    <= '0;
         r_room   <= '0;
         r_count  <= '0;
         r_signal <= '0;
         r_update <= 1'b0;
      end else begin
         r_update <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_sample_d) begin
                  r_snap <= r_st;
                  r_idx  <= '0;
                  r_acc  <= '0;
               end
            end
            S_SCAN: begin
               r_acc <= r_acc + 5'(r_snap[r_idx]);
               r_idx <= r_idx + 4'd1;
            end
            S_PUBLISH: begin
               r_room   <= r_snap;
               r_count  <= 8'(r_acc);
               r_signal <= w_sev;
               r_update <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign room   = r_room;
   assign count  = r_count;
   assign signal = r_signal;
   assign update = r_update;

endmodule

// File: tb/tb_fire_sensor_scanner.sv
// Directed bench for fire_sensor_scanner with a short sample period.
module tb_fire_sensor_scanner;

   localparam int TICK = 24;
   localparam int LAT  = TICK + 18;   // release-to-first-update, in cycles

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sensor_raw = '0;
   logic [15:0] room_mask = '0;
   logic [15:0] room;
   logic [7:0]  count;
   logic [1:0]  signal;
   logic        update;

   int errors = 0;
   int checks = 0;
   int n;

   fire_sensor_scanner #(
      .TICK_DIV    (TICK),
      .DEBOUNCE    (4),
      .MAJOR_THRESH(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sensor_raw(sensor_raw),
      .room_mask (room_mask),
      .room      (room),
      .count     (count),
      .signal    (signal),
      .update    (update)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for the update strobe, sampling on falling edges.
   task automatic wait_upd(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (update !== 1'b1 && cyc < 200);
      check("upd_seen", 32'(update), 32'd1);
   endtask

   task automatic pub(input string tag, input logic [15:0] e_room,
                      input logic [7:0] e_cnt, input logic [1:0] e_sig);
      int c;
      wait_upd(c);
      check({tag, "_room"},   32'(room),   32'(e_room));
      check({tag, "_count"},  32'(count),  32'(e_cnt));
      check({tag, "_signal"}, 32'(signal), 32'(e_sig));
      @(negedge clk);
      check({tag, "_pulse"},  32'(update), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_room",   32'(room),   32'd0);
      check("rst_count",  32'(count),  32'd0);
      check("rst_signal", 32'(signal), 32'd0);
      check("rst_update", 32'(update), 32'd0);
      reset = 1'b0;

      // First-update latency and period with idle sensors
      wait_upd(n);
      check("first_latency", 32'(n), 32'(LAT));
      check("idle_room", 32'(room), 32'd0);
      wait_upd(n);
      check("period", 32'(n), 32'(TICK));
      pub("idle", 16'h0000, 8'd0, 2'b00);

      // Glitch of three samples is rejected
      sensor_raw = 16'h0008;
      for (int i = 0; i < 3; i++) pub("glitch", 16'h0000, 8'd0, 2'b00);
      sensor_raw = 16'h0000;
      pub("glitch_end", 16'h0000, 8'd0, 2'b00);

      // Held room 3 confirms on the fourth sample
      sensor_raw = 16'h0008;
      for (int i = 0; i < 3; i++) pub("r3_wait", 16'h0000, 8'd0, 2'b00);
      pub("r3_on", 16'h0008, 8'd1, 2'b01);

      // Clearing needs four agreeing samples too
      sensor_raw = 16'h0000;
      for (int i = 0; i < 3; i++) pub("r3_hold", 16'h0008, 8'd1, 2'b01);
      pub("r3_off", 16'h0000, 8'd0, 2'b00);

      // Severity levels
      sensor_raw = 16'h0007;
      for (int i = 0; i < 3; i++) pub("m3_wait", 16'h0000, 8'd0, 2'b00);
      pub("multi3", 16'h0007, 8'd3, 2'b10);
      sensor_raw = 16'h000F;
      for (int i = 0; i < 3; i++) pub("m4_wait", 16'h0007, 8'd3, 2'b10);
      pub("major4", 16'h000F, 8'd4, 2'b11);
      sensor_raw = 16'hFFFF;
      for (int i = 0; i < 3; i++) pub("all_wait", 16'h000F, 8'd4, 2'b11);
      pub("all16", 16'hFFFF, 8'd16, 2'b11);

      // Mask overrides a confirmed fire; unmask restarts debounce
      sensor_raw = 16'h0020;
      for (int i = 0; i < 3; i++) pub("r5_wait", 16'hFFFF, 8'd16, 2'b11);
      pub("r5_on", 16'h0020, 8'd1, 2'b01);
      room_mask = 16'h0020;
      pub("r5_masked", 16'h0000, 8'd0, 2'b00);
      room_mask = 16'h0000;
      for (int i = 0; i < 3; i++) pub("r5_rearm", 16'h0000, 8'd0, 2'b00);
      pub("r5_back", 16'h0020, 8'd1, 2'b01);

      // Reset during a scan abandons it and clears debounce history
      sensor_raw = 16'h00FF;
      for (int i = 0; i < 3; i++) pub("ff_wait", 16'h0020, 8'd1, 2'b01);
      pub("ff_on", 16'h00FF, 8'd8, 2'b11);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_room",   32'(room),   32'd0);
      check("mid_rst_count",  32'(count),  32'd0);
      check("mid_rst_signal", 32'(signal), 32'd0);
      check("mid_rst_update", 32'(update), 32'd0);
      reset = 1'b0;
      wait_upd(n);
      check("rst_latency", 32'(n), 32'(LAT));
      check("rst_u1_room", 32'(room), 32'd0);
      for (int i = 0; i < 2; i++) pub("rst_rearm", 16'h0000, 8'd0, 2'b00);
      pub("rst_ff", 16'h00FF, 8'd8, 2'b11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
